// File: rtl/jk_mod_counter.sv
// jk_mod_counter: WIDTH-bit JK register with hold/mod-up/mod-down/per-bit JK modes, tc and wrap outputs
// Define JK_MOD_COUNTER_SAT_EN to saturate at the terminal values instead of wrapping.
module jk_mod_counter #(
  parameter int     WIDTH     = 4,
  parameter longint MOD_VAL   = 16,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD_VAL - 64'sd1);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
`ifdef JK_MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  generate
    if (WIDTH < 1 || WIDTH > 32 || MOD_VAL < 64'sd2 || MOD_VAL > (64'sd1 <<< WIDTH) ||
        RESET_VAL < 64'sd0 || RESET_VAL >= MOD_VAL) begin : g_bad_params
      $error("jk_mod_counter: illegal WIDTH/MOD_VAL/RESET_VAL");
    end
  endgenerate
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             at_top, at_zero;
  assign at_top  = q == TOP;
  assign at_zero = q == '0;
  assign tc = en & ~sync_clr & ((mode == 2'b01 & at_top) | (mode == 2'b10 & at_zero));
  // Values above TOP can only come from JK mode; they snap back into range without a wrap pulse.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (sync_clr) q_next = RST;
    else if (en) begin
      case (mode)
        2'b01: begin
          q_next    = at_top ? (SAT ? q : '0) : (q > TOP ? '0 : q + WIDTH'(1));
          wrap_next = at_top & ~SAT;
        end
        2'b10: begin
          q_next    = at_zero ? (SAT ? q : TOP) : (q > TOP ? TOP : q - WIDTH'(1));
          wrap_next = at_zero & ~SAT;
        end
        2'b11: q_next = (j & ~q) | (~k & q);
        default: q_next = q;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q    <= RST;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed self-checking bench, WIDTH=4 MOD_VAL=10 with RESET_VAL=0 and RESET_VAL=3 instances
module tb_jk_mod_counter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sync_clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] j = '0, k = '0;
  logic [3:0] qa, qb;
  logic tca, tcb, wrapa, wrapb;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MOD_VAL(10), .RESET_VAL(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .mode(mode),
    .j(j), .k(k), .q(qa), .tc(tca), .wrap(wrapa));
  jk_mod_counter #(.WIDTH(4), .MOD_VAL(10), .RESET_VAL(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .mode(mode),
    .j(j), .k(k), .q(qb), .tc(tcb), .wrap(wrapb));

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    #12;
    chk4("reset_qa", qa, 4'd0);
    chk4("reset_qb", qb, 4'd3);
    chk1("reset_wrap", wrapa, 1'b0);
    rst = 1'b0;
    // async reset mid-count
    en = 1'b1; mode = 2'b01;
    repeat (7) step();
    chk4("count_to_7", qa, 4'd7);
    rst_pulse();
    #1;
    chk4("async_rst_q", qa, 4'd0);
    chk1("async_rst_wrap", wrapa, 1'b0);
    step();
    chk4("first_after_rst", qa, 4'd1);
    chk1("first_after_rst_wrap", wrapa, 1'b0);
    // up wrap
    rst_pulse();
    for (int i = 1; i <= 12; i++) begin
      chk1("up_tc", tca, ((i - 1) % 10) == 9);
      step();
      e = 4'(i % 10);
      chk4("up_q", qa, e);
      chk1("up_wrap", wrapa, e == 4'd0);
    end
    // down wrap with hold
    mode = 2'b10;
    step();
    chk4("down_q1", qa, 4'd1);
    step();
    chk4("down_q0", qa, 4'd0);
    chk1("down_nowrap", wrapa, 1'b0);
    chk1("down_tc", tca, 1'b1);
    en = 1'b0;
    #1 chk1("hold_tc", tca, 1'b0);
    step(); step();
    chk4("hold_q", qa, 4'd0);
    chk1("hold_wrap", wrapa, 1'b0);
    en = 1'b1;
    step();
    chk4("down_wrap_q", qa, 4'd9);
    chk1("down_wrap_pulse", wrapa, 1'b1);
    step();
    chk4("down_q8", qa, 4'd8);
    chk1("down_wrap_end", wrapa, 1'b0);
    // JK mode
    mode = 2'b11; j = 4'b0101; k = 4'b1010;
    step();
    chk4("jk_load", qa, 4'b0101);
    j = 4'b1100; k = 4'b0110;
    step();
    chk4("jk_mix", qa, 4'b1001);
    j = 4'b1110; k = 4'b0000;
    step();
    chk4("jk_set", qa, 4'b1111);
    chk1("jk_tc", tca, 1'b0);
    chk1("jk_wrap", wrapa, 1'b0);
    mode = 2'b01;
    #1 chk1("oor_up_tc", tca, 1'b0);
    step();
    chk4("oor_up_q", qa, 4'd0);
    chk1("oor_up_wrap", wrapa, 1'b0);
    mode = 2'b11; j = 4'b1111; k = 4'b0000;
    step();
    mode = 2'b10;
    step();
    chk4("oor_down_q", qa, 4'd9);
    chk1("oor_down_wrap", wrapa, 1'b0);
    // mode 00 hold
    mode = 2'b00;
    #1 chk1("mode0_tc", tca, 1'b0);
    step();
    chk4("mode0_q", qa, 4'd9);
    // priority: sync_clr beats en/mode
    mode = 2'b11; j = 4'b1001; k = 4'b0110;
    step();
    chk4("prio_pre_qb", qb, 4'd9);
    mode = 2'b01;
    #1 chk1("prio_pre_tca", tca, 1'b1);
    sync_clr = 1'b1;
    #1;
    chk1("prio_tca", tca, 1'b0);
    chk1("prio_tcb", tcb, 1'b0);
    step();
    chk4("prio_qa", qa, 4'd0);
    chk4("prio_qb", qb, 4'd3);
    chk1("prio_wrapa", wrapa, 1'b0);
    chk1("prio_wrapb", wrapb, 1'b0);
    en = 1'b0;
    step();
    chk4("clr_no_en_qb", qb, 4'd3);
    sync_clr = 1'b0; en = 1'b1;
    step();
    chk4("after_clr_qb", qb, 4'd4);
`ifdef JK_MOD_COUNTER_SAT_EN
    mode = 2'b11; j = 4'b1000; k = 4'b0111;
    step();
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk4("sat_up_q", qa, 4'd9);
      chk1("sat_up_wrap", wrapa, 1'b0);
    end
    chk1("sat_up_tc", tca, 1'b1);
    mode = 2'b11; j = 4'b0001; k = 4'b1110;
    step();
    mode = 2'b10;
    for (int i = 0; i < 2; i++) begin
      step();
      chk4("sat_down_q", qa, 4'd0);
      chk1("sat_down_wrap", wrapa, 1'b0);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
